// File: rtl/l3_wr_exec_if.sv
// Command, write-data and register-bus signals of the L3 write executor.
// The master modport is the executor's view; slave is the surrounding parser and bus.
interface l3_wr_exec_if;
    logic [3:0]  l3_sel;
    logic [3:0]  l3_id;
    logic [7:0]  l3_op;
    logic [15:0] l3_size;
    logic [15:0] l3_extend;
    logic        l3_en;
    logic        l3_cmd_done;
    logic [31:0] l3_wd;
    logic        l3_wd_vld;
    logic        l3_wd_rdy;
    logic        l3_err;
    logic [3:0]  l3_last_id;
    logic        bus_req;
    logic [3:0]  bus_sel;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    modport master (
        input  l3_sel, l3_id, l3_op, l3_size, l3_extend, l3_en,
        input  l3_wd, l3_wd_vld, bus_ack,
        output l3_cmd_done, l3_wd_rdy, l3_err, l3_last_id,
        output bus_req, bus_sel, bus_addr, bus_wdata, bus_be
    );

    modport slave (
        output l3_sel, l3_id, l3_op, l3_size, l3_extend, l3_en,
        output l3_wd, l3_wd_vld, bus_ack,
        input  l3_cmd_done, l3_wd_rdy, l3_err, l3_last_id,
        input  bus_req, bus_sel, bus_addr, bus_wdata, bus_be
    );
endinterface

// File: rtl/l3_wr_exec.sv
// L3 write executor: turns a decoded L3 write command into single-beat register-bus writes.
// Optional macro L3_WR_TIMEOUT_EN abandons a command after 256 cycles without bus_ack.
module l3_wr_exec (
    input  logic         clk,
    input  logic         rst,
    l3_wr_exec_if.master io
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        WAIT_WD = 4'b0010,
        BUS     = 4'b0100,
        DONE    = 4'b1000
    } state_t;

    localparam logic [7:0] OP_INCR  = 8'h01;
    localparam logic [7:0] OP_FIXED = 8'h02;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
`ifdef L3_WR_TIMEOUT_EN
    logic [7:0]  tmo_q, tmo_d;
`endif

    // Byte lanes are filled from [31:24] downward, so a short tail keeps the upper lanes.
    function automatic logic [3:0] tail_be(input logic [15:0] rem);
        if (rem >= 16'd4) return 4'b1111;
        case (rem[1:0])
            2'd1:    return 4'b1000;
            2'd2:    return 4'b1100;
            2'd3:    return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] rem_after_beat(input logic [15:0] rem);
        return (rem < 16'd4) ? 16'd0 : rem - 16'd4;
    endfunction

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        id_d    = id_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
`ifdef L3_WR_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (io.l3_en) begin
                    sel_d  = io.l3_sel;
                    id_d   = io.l3_id;
                    op_d   = io.l3_op;
                    addr_d = {io.l3_extend[15:2], 2'b00};
                    rem_d  = io.l3_size;
                    err_d  = 1'b0;
                    if (io.l3_op != OP_INCR && io.l3_op != OP_FIXED) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (io.l3_size == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_WD;
                    end
                end
            end
            WAIT_WD: begin
                if (io.l3_wd_vld) begin
                    wdata_d = io.l3_wd;
                    be_d    = tail_be(rem_q);
                    state_d = BUS;
`ifdef L3_WR_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end
            end
            BUS: begin
                if (io.bus_ack) begin
                    rem_d = rem_after_beat(rem_q);
                    if (op_q == OP_INCR) addr_d = addr_q + 16'd4;
                    state_d = (rem_d == 16'd0) ? DONE : WAIT_WD;
                end
`ifdef L3_WR_TIMEOUT_EN
                else if (tmo_q == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
`ifdef L3_WR_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
`ifdef L3_WR_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Every output is a plain decode of registered state.
    assign io.l3_wd_rdy   = (state_q == WAIT_WD);
    assign io.bus_req     = (state_q == BUS);
    assign io.l3_cmd_done = (state_q == DONE);
    assign io.l3_err      = err_q;
    assign io.l3_last_id  = id_q;
    assign io.bus_sel     = sel_q;
    assign io.bus_addr    = addr_q;
    assign io.bus_wdata   = wdata_q;
    assign io.bus_be      = be_q;

    logic unused_ext_lsbs;
    assign unused_ext_lsbs = ^io.l3_extend[1:0];

endmodule

// File: tb/tb_l3_wr_exec.sv
// Directed bench for l3_wr_exec: reset, incrementing/fixed writes, zero size, bad op,
// backpressure, and reset-in-BUS (or timeout when L3_WR_TIMEOUT_EN is defined).
module tb_l3_wr_exec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    l3_wr_exec_if bif();

    l3_wr_exec dut (
        .clk (clk),
        .rst (rst),
        .io  (bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle l3_en; returns in cycle 1 relative to the pulse.
    task automatic send_cmd(input logic [3:0] sel, input logic [3:0] id, input logic [7:0] op,
                            input logic [15:0] size, input logic [15:0] ext);
        bif.l3_sel    = sel;
        bif.l3_id     = id;
        bif.l3_op     = op;
        bif.l3_size   = size;
        bif.l3_extend = ext;
        bif.l3_en     = 1'b1;
        step();
        bif.l3_en     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({bif.l3_wd_rdy, bif.bus_req, bif.l3_cmd_done, bif.l3_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bif.l3_wd_rdy, bif.bus_req, bif.l3_cmd_done, bif.l3_err});
        end
        checks++;
        if (bif.l3_last_id !== 4'h0) begin
            errors++; $display("FAIL reset_last_id: got %h want 0", bif.l3_last_id);
        end
        checks++;
        if (bif.bus_addr !== 16'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", bif.bus_addr);
        end
        checks++;
        if (bif.bus_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_wdata: got %h want 0", bif.bus_wdata);
        end
        checks++;
        if ({bif.bus_be, bif.bus_sel} !== 8'h00) begin
            errors++; $display("FAIL reset_be_sel: got %h want 00", {bif.bus_be, bif.bus_sel});
        end
        step();
    endtask

    task automatic test_incr();
        send_cmd(4'h3, 4'h5, 8'h01, 16'd8, 16'h0100);
        checks++;
        if ({bif.l3_wd_rdy, bif.l3_err, bif.l3_last_id} !== {1'b1, 1'b0, 4'h5}) begin
            errors++;
            $display("FAIL incr_start: got rdy/err/id %b/%b/%h want 1/0/5",
                     bif.l3_wd_rdy, bif.l3_err, bif.l3_last_id);
        end
        bif.l3_wd = 32'hA1B2C3D4;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd_vld = 1'b0;
        checks++;
        if ({bif.bus_req, bif.bus_sel, bif.bus_addr, bif.bus_wdata, bif.bus_be} !==
            {1'b1, 4'h3, 16'h0100, 32'hA1B2C3D4, 4'hF}) begin
            errors++;
            $display("FAIL incr_beat0: got req=%b sel=%h addr=%h wd=%h be=%b want 1/3/0100/a1b2c3d4/1111",
                     bif.bus_req, bif.bus_sel, bif.bus_addr, bif.bus_wdata, bif.bus_be);
        end
        step();
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        checks++;
        if ({bif.l3_wd_rdy, bif.bus_req, bif.l3_cmd_done} !== 3'b100) begin
            errors++;
            $display("FAIL incr_after_ack0: got rdy/req/done %b want 100",
                     {bif.l3_wd_rdy, bif.bus_req, bif.l3_cmd_done});
        end
        bif.l3_wd = 32'h11223344;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd_vld = 1'b0;
        checks++;
        if ({bif.bus_req, bif.bus_addr, bif.bus_wdata, bif.bus_be} !==
            {1'b1, 16'h0104, 32'h11223344, 4'hF}) begin
            errors++;
            $display("FAIL incr_beat1: got req=%b addr=%h wd=%h be=%b want 1/0104/11223344/1111",
                     bif.bus_req, bif.bus_addr, bif.bus_wdata, bif.bus_be);
        end
        step();
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        checks++;
        if ({bif.l3_cmd_done, bif.l3_err, bif.bus_req} !== 3'b100) begin
            errors++;
            $display("FAIL incr_done: got done/err/req %b want 100",
                     {bif.l3_cmd_done, bif.l3_err, bif.bus_req});
        end
        step();
        checks++;
        if (bif.l3_cmd_done !== 1'b0) begin
            errors++; $display("FAIL incr_done_width: got done=%b want 0", bif.l3_cmd_done);
        end
    endtask

    task automatic test_partial_tail();
        send_cmd(4'hA, 4'h6, 8'h02, 16'd6, 16'h0203);
        bif.l3_wd = 32'hCAFEF00D;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd_vld = 1'b0;
        checks++;
        if ({bif.bus_req, bif.bus_addr, bif.bus_be} !== {1'b1, 16'h0200, 4'b1111}) begin
            errors++;
            $display("FAIL tail_beat0: got req=%b addr=%h be=%b want 1/0200/1111",
                     bif.bus_req, bif.bus_addr, bif.bus_be);
        end
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        checks++;
        if ({bif.l3_wd_rdy, bif.l3_cmd_done} !== 2'b10) begin
            errors++;
            $display("FAIL tail_mid: got rdy/done %b want 10", {bif.l3_wd_rdy, bif.l3_cmd_done});
        end
        bif.l3_wd = 32'hBEEF0000;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd_vld = 1'b0;
        checks++;
        if ({bif.bus_req, bif.bus_addr, bif.bus_be, bif.bus_wdata} !==
            {1'b1, 16'h0200, 4'b1100, 32'hBEEF0000}) begin
            errors++;
            $display("FAIL tail_beat1: got req=%b addr=%h be=%b wd=%h want 1/0200/1100/beef0000",
                     bif.bus_req, bif.bus_addr, bif.bus_be, bif.bus_wdata);
        end
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        checks++;
        if ({bif.l3_cmd_done, bif.l3_err} !== 2'b10) begin
            errors++;
            $display("FAIL tail_done: got done/err %b want 10", {bif.l3_cmd_done, bif.l3_err});
        end
        step();
    endtask

    task automatic test_zero_size();
        send_cmd(4'h1, 4'h7, 8'h01, 16'd0, 16'h0010);
        checks++;
        if ({bif.l3_cmd_done, bif.bus_req, bif.l3_wd_rdy, bif.l3_err} !== 4'b1000) begin
            errors++;
            $display("FAIL zero_done: got done/req/rdy/err %b want 1000",
                     {bif.l3_cmd_done, bif.bus_req, bif.l3_wd_rdy, bif.l3_err});
        end
        // A stray ack with no request outstanding must change nothing.
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bif.l3_cmd_done, bif.bus_req, bif.l3_wd_rdy} !== 3'b000) begin
                errors++;
                $display("FAIL zero_idle[%0d]: got done/req/rdy %b want 000", i,
                         {bif.l3_cmd_done, bif.bus_req, bif.l3_wd_rdy});
            end
            step();
        end
    endtask

    task automatic test_bad_op();
        send_cmd(4'h2, 4'h8, 8'h7F, 16'd4, 16'h0000);
        checks++;
        if ({bif.l3_cmd_done, bif.l3_err, bif.l3_wd_rdy, bif.l3_last_id} !== {3'b110, 4'h8}) begin
            errors++;
            $display("FAIL badop_done: got done/err/rdy %b id %h want 110 id 8",
                     {bif.l3_cmd_done, bif.l3_err, bif.l3_wd_rdy}, bif.l3_last_id);
        end
        step();
        checks++;
        if ({bif.l3_err, bif.l3_cmd_done} !== 2'b10) begin
            errors++;
            $display("FAIL badop_sticky: got err/done %b want 10", {bif.l3_err, bif.l3_cmd_done});
        end
        send_cmd(4'h2, 4'h9, 8'h01, 16'd4, 16'h0020);
        checks++;
        if ({bif.l3_err, bif.l3_wd_rdy, bif.l3_last_id} !== {2'b01, 4'h9}) begin
            errors++;
            $display("FAIL badop_clear: got err/rdy %b id %h want 01 id 9",
                     {bif.l3_err, bif.l3_wd_rdy}, bif.l3_last_id);
        end
        bif.l3_wd = 32'h0BADF00D;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd_vld = 1'b0;
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        checks++;
        if ({bif.l3_cmd_done, bif.l3_err} !== 2'b10) begin
            errors++;
            $display("FAIL badop_next_done: got done/err %b want 10", {bif.l3_cmd_done, bif.l3_err});
        end
        step();
    endtask

    task automatic test_backpressure();
        send_cmd(4'h5, 4'hB, 8'h01, 16'd8, 16'h0040);
        bif.l3_wd = 32'hDEADBEEF;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd = 32'h01020304;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bif.bus_req, bif.l3_wd_rdy, bif.bus_sel, bif.bus_addr, bif.bus_wdata, bif.bus_be} !==
                {1'b1, 1'b0, 4'h5, 16'h0040, 32'hDEADBEEF, 4'hF}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got req=%b rdy=%b sel=%h addr=%h wd=%h be=%b want 1/0/5/0040/deadbeef/1111",
                         i, bif.bus_req, bif.l3_wd_rdy, bif.bus_sel, bif.bus_addr, bif.bus_wdata, bif.bus_be);
            end
            bif.l3_en  = (i == 3);
            bif.l3_id  = 4'hC;
            bif.bus_ack = (i == 9);
            step();
        end
        bif.l3_en = 1'b0;
        bif.bus_ack = 1'b0;
        checks++;
        if ({bif.l3_wd_rdy, bif.bus_req, bif.l3_last_id, bif.l3_err} !== {2'b10, 4'hB, 1'b0}) begin
            errors++;
            $display("FAIL bp_after_ack: got rdy/req %b id %h err %b want 10 id b err 0",
                     {bif.l3_wd_rdy, bif.bus_req}, bif.l3_last_id, bif.l3_err);
        end
        step();
        bif.l3_wd_vld = 1'b0;
        checks++;
        if ({bif.bus_req, bif.bus_addr, bif.bus_wdata} !== {1'b1, 16'h0044, 32'h01020304}) begin
            errors++;
            $display("FAIL bp_beat1: got req=%b addr=%h wd=%h want 1/0044/01020304",
                     bif.bus_req, bif.bus_addr, bif.bus_wdata);
        end
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        checks++;
        if ({bif.l3_cmd_done, bif.l3_last_id} !== {1'b1, 4'hB}) begin
            errors++;
            $display("FAIL bp_done: got done=%b id=%h want 1/b", bif.l3_cmd_done, bif.l3_last_id);
        end
        step();
    endtask

`ifdef L3_WR_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        send_cmd(4'h6, 4'hD, 8'h01, 16'd8, 16'h0080);
        bif.l3_wd = 32'h55AA55AA;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd_vld = 1'b0;
        checks++;
        if (bif.bus_req !== 1'b1) begin
            errors++; $display("FAIL tmo_req: got req=%b want 1", bif.bus_req);
        end
        n = 0;
        while (bif.l3_cmd_done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n != 256) begin
            errors++; $display("FAIL tmo_latency: got %0d cycles want 256", n);
        end
        checks++;
        if ({bif.l3_err, bif.bus_req} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_err: got err/req %b want 10", {bif.l3_err, bif.bus_req});
        end
        step();
    endtask
`else
    task automatic test_reset_mid();
        send_cmd(4'h6, 4'hD, 8'h01, 16'd8, 16'h0080);
        bif.l3_wd = 32'h55AA55AA;
        bif.l3_wd_vld = 1'b1;
        step();
        bif.l3_wd_vld = 1'b0;
        checks++;
        if ({bif.bus_req, bif.bus_addr} !== {1'b1, 16'h0080}) begin
            errors++;
            $display("FAIL rstmid_req: got req=%b addr=%h want 1/0080", bif.bus_req, bif.bus_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bif.l3_wd_rdy, bif.bus_req, bif.l3_cmd_done, bif.l3_err, bif.l3_last_id,
             bif.bus_sel, bif.bus_addr, bif.bus_wdata, bif.bus_be} !== 68'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got rdy=%b req=%b done=%b err=%b id=%h sel=%h addr=%h wd=%h be=%b want all 0",
                     bif.l3_wd_rdy, bif.bus_req, bif.l3_cmd_done, bif.l3_err, bif.l3_last_id,
                     bif.bus_sel, bif.bus_addr, bif.bus_wdata, bif.bus_be);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bif.l3_cmd_done, bif.bus_req} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_quiet[%0d]: got done/req %b want 00", i,
                         {bif.l3_cmd_done, bif.bus_req});
            end
        end
    endtask
`endif

    initial begin
        bif.l3_sel = '0;
        bif.l3_id = '0;
        bif.l3_op = '0;
        bif.l3_size = '0;
        bif.l3_extend = '0;
        bif.l3_en = 1'b0;
        bif.l3_wd = '0;
        bif.l3_wd_vld = 1'b0;
        bif.bus_ack = 1'b0;
        test_reset();
        test_incr();
        test_partial_tail();
        test_zero_size();
        test_bad_op();
        test_backpressure();
`ifdef L3_WR_TIMEOUT_EN
        test_timeout();
`else
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
